pkt_rr_arb_mux: RTL and testbench
=================================

// Module: pkt_rr_arb_mux
// PURPOSE
//  Packet-aware N:1 round-robin arbitrated mux with valid/ready handshake on every port.
//  Sits downstream of the requestor queues and uses the team's round-robin grant scheme.
//  Locks the grant for a whole packet (first beat through in_last beat).
//  Registers the winning beat into a single output stage that drives the shared consumer.
// PARAMETERS
//  NUM_REQ  4   number of requestors, >=2
//  DATA_W   32  payload width per beat
//  SRC_W    $clog2(NUM_REQ)  width of out_src (localparam)
// PORTS
//  clk        in   1               clock, all state on posedge
//  rst_b      in   1               asynchronous, active-low reset
//  in_valid   in   NUM_REQ         per-requestor beat valid
//  in_data    in   NUM_REQ*DATA_W  payloads; requestor i at [i*DATA_W +: DATA_W]
//  in_last    in   NUM_REQ         beat is final beat of packet
//  in_ready   out  NUM_REQ         beat of requestor i accepted this cycle
//  out_valid  out  1               output register holds a beat
//  out_data   out  DATA_W          registered payload
//  out_last   out  1               registered last flag
//  out_src    out  SRC_W           index of requestor that sourced the beat
//  out_ready  in   1               consumer accepts the output beat
// BEHAVIOUR
//  Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, state=IDLE,
//    rr_ptr=NUM_REQ-1, lock_id=0. in_ready is 0 during reset.
//  can_acc = !out_valid | out_ready. The output register loads when can_acc and a beat is accepted.
//  in_ready[i] = can_acc & (i == sel). in_ready may depend combinationally on in_valid and out_ready.
//  FSM IDLE:
//    sel = first valid requestor scanning rr_ptr+1, rr_ptr+2, ... with modulo-NUM_REQ wrap.
//    No in_valid -> sel is none, all in_ready=0.
//    On accept: rr_ptr<=sel. If in_last[sel]=0, go to LOCKED and set lock_id<=sel.
//    A single-beat packet (last=1) stays in IDLE.
//  FSM LOCKED:
//    sel=lock_id regardless of other in_valid. in_ready=0 for all others.
//    in_valid[lock_id]=0 inserts a bubble; the lock is held and no other requestor is served.
//    Accepted beat with in_last=1 -> IDLE. The next arbitration starts from lock_id+1.
//    rr_ptr is unchanged while LOCKED.
//  Output register:
//    On load: out_valid<=1; out_data/out_last/out_src take the selected beat.
//    Else if out_ready: out_valid<=0.
//    out_* are held stable while out_valid & !out_ready.
//  Latency is 1 cycle from input accept to out_valid.
//  Full throughput is 1 beat/cycle when out_ready is held at 1.
//  Back-pressure: out_valid & !out_ready -> all in_ready=0, and state and rr_ptr are frozen.
//  Reset asserted mid-packet aborts the packet:
//    all state returns to reset values and the in-flight output beat is dropped.
//  Fairness: with all requestors continuously valid, each single-beat requestor is granted
//    once per NUM_REQ grants.
// TESTING
//  1 Reset, all valid=1, last=1, out_ready=1:
//    out_src sequence 0,1,2,3,0,...; one beat per cycle from cycle 1.
//  2 Req1 sends a 3-beat packet (A1,A2,A3) while req0/req2 are valid:
//    out_data A1,A2,A3 are contiguous with out_src=1; next grant goes to req2.
//  3 out_valid=1, out_ready=0 for 5 cycles:
//    out_* are stable, in_ready=0, then transfers resume without loss or duplication.
//  4 Locked req3 drops in_valid for 2 cycles mid-packet while req0 is valid:
//    req0 is not granted until req3's last beat has been accepted.
//  5 Assert rst_b=0 during beat 2 of 4:
//    out_valid=0 within the same cycle (async); after release the first grant is req0.
//  6 Only req2 valid with a stream of single-beat packets:
//    grant goes to req2 every cycle, rr_ptr=2, and no bubbles appear.

Source files
------------

// File: rtl/pkt_rr_arb_mux.sv
// Packet-aware N:1 round-robin arbitrated mux with a single registered output stage.
// The grant is held for a whole packet, from its first beat through the in_last beat.
module pkt_rr_arb_mux #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    localparam int unsigned SRC_W  = $clog2(NUM_REQ)
) (
    input  logic                        clk,
    input  logic                        rst_b,
    input  logic [NUM_REQ-1:0]          in_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   in_data,
    input  logic [NUM_REQ-1:0]          in_last,
    output logic [NUM_REQ-1:0]          in_ready,
    output logic                        out_valid,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [SRC_W-1:0]            out_src,
    input  logic                        out_ready
);

    typedef enum logic {
        IDLE,
        LOCKED
    } state_e;

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [SRC_W-1:0]   lock_id_q, lock_id_d;
    logic [SRC_W-1:0]   sel;
    logic               have_sel;
    logic               can_acc;
    logic               accept;

    logic               out_valid_q;
    logic [DATA_W-1:0]  out_data_q;
    logic               out_last_q;
    logic [SRC_W-1:0]   out_src_q;

    assign can_acc = !out_valid_q || out_ready;

    // Scan runs from the farthest slot back to rr_ptr+1 so the nearest valid requestor wins last.
    always_comb begin : arb
        int unsigned idx;
        idx      = 0;
        sel      = lock_id_q;
        have_sel = 1'b1;
        if (state_q == IDLE) begin
            sel      = '0;
            have_sel = 1'b0;
            for (int unsigned k = NUM_REQ; k >= 1; k--) begin
                idx = (int'(rr_ptr_q) + k) % NUM_REQ;
                if (in_valid[idx[SRC_W-1:0]]) begin
                    sel      = idx[SRC_W-1:0];
                    have_sel = 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        if (rst_b && can_acc && have_sel) begin
            in_ready[sel] = 1'b1;
        end
    end

    assign accept = in_ready[sel] & in_valid[sel];

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            unique case (state_q)
                IDLE: begin
                    rr_ptr_d = sel;
                    if (!in_last[sel]) begin
                        state_d   = LOCKED;
                        lock_id_d = sel;
                    end
                end
                LOCKED: begin
                    if (in_last[sel]) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            rr_ptr_q  <= SRC_W'(NUM_REQ - 1);
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_id_q <= lock_id_d;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_src_q   <= '0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_data_q  <= in_data[sel*DATA_W +: DATA_W];
            out_last_q  <= in_last[sel];
            out_src_q   <= sel;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_pkt_rr_arb_mux.sv
// Bench for pkt_rr_arb_mux: directed scenarios plus randomized packet traffic
// checked against a transaction-level arbitration model.
module tb_pkt_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst_b;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic [1:0]     out_src;
    logic           out_ready;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: packet ownership, last winner, and contents of the output slot.
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    bit          m_ov;
    logic [W-1:0] m_od;
    bit          m_ol;
    int          m_os;
    int          acc_id;
    logic [N-1:0] exp_rdy;

    pkt_rr_arb_mux #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk), .rst_b(rst_b),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic int pick();
        if (m_locked) return m_owner;
        for (int k = 1; k <= N; k++) begin
            int r = (m_ptr + k) % N;
            if (in_valid[r]) return r;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_locked = 0; m_owner = 0; m_ptr = N - 1;
        m_ov = 0; m_od = '0; m_ol = 0; m_os = 0;
    endtask

    // Called once inputs are driven; settles, then predicts ready and the winner.
    task automatic model_eval();
        int w;
        #1;
        w = pick();
        exp_rdy = '0;
        acc_id = -1;
        if (rst_b && (!m_ov || out_ready) && w >= 0) begin
            exp_rdy = N'(1 << w);
            if (in_valid[w]) acc_id = w;
        end
    endtask

    task automatic model_clock();
        if (acc_id >= 0) begin
            m_ov = 1;
            m_od = in_data[acc_id*W +: W];
            m_ol = in_last[acc_id];
            m_os = acc_id;
            if (!m_locked) begin
                m_ptr = acc_id;
                if (!in_last[acc_id]) begin
                    m_locked = 1;
                    m_owner = acc_id;
                end
            end else if (in_last[acc_id]) begin
                m_locked = 0;
            end
        end else if (out_ready) begin
            m_ov = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_data_random();
        for (int i = 0; i < N; i++) in_data[i*W +: W] = $urandom;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        set_data_random();
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_bad++; $display("FAIL rst_out_data: got %0h want 0", out_data); end
        n_cmp++; if (out_last !== 1'b0) begin n_bad++; $display("FAIL rst_out_last: got %0b want 0", out_last); end
        n_cmp++; if (out_src !== 2'd0) begin n_bad++; $display("FAIL rst_out_src: got %0d want 0", out_src); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL rst_in_ready: got %b want 0000", in_ready); end
        rst_b = 1'b1;
        model_reset();
    endtask

    task automatic test_round_robin();
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            set_data_random();
            model_eval();
            n_cmp++; if (in_ready !== 4'(1 << (k % N))) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", k, in_ready, 4'(1 << (k % N))); end
            model_clock();
            n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rr_valid[%0d]: got %0b want 1", k, out_valid); end
            n_cmp++; if (out_src !== 2'(k % N)) begin n_bad++; $display("FAIL rr_src[%0d]: got %0d want %0d", k, out_src, k % N); end
            n_cmp++; if (out_data !== m_od) begin n_bad++; $display("FAIL rr_data[%0d]: got %0h want %0h", k, out_data, m_od); end
        end
    endtask

    task automatic test_packet();
        logic [N-1:0] vs [4] = '{4'b0010, 4'b0111, 4'b0111, 4'b0101};
        logic [N-1:0] ls [4] = '{4'b1101, 4'b1101, 4'b1111, 4'b1111};
        int           es [4] = '{1, 1, 1, 2};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_data_random();
            in_data[1*W +: W] = 32'hA000_0001 + k;
            in_valid = vs[k];
            in_last = ls[k];
            model_eval();
            model_clock();
            n_cmp++; if (out_src !== 2'(es[k])) begin n_bad++; $display("FAIL pkt_src[%0d]: got %0d want %0d", k, out_src, es[k]); end
            if (k < 3) begin
                n_cmp++; if (out_data !== 32'hA000_0001 + k) begin n_bad++; $display("FAIL pkt_data[%0d]: got %0h want %0h", k, out_data, 32'hA000_0001 + k); end
                n_cmp++; if (out_last !== (k == 2)) begin n_bad++; $display("FAIL pkt_last[%0d]: got %0b want %0b", k, out_last, k == 2); end
            end
        end
    endtask

    task automatic test_backpressure();
        in_valid = '1; in_last = '1; out_ready = 1'b1;
        set_data_random();
        model_eval();
        model_clock();
        out_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            set_data_random();
            model_eval();
            n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0000", k, in_ready); end
            model_clock();
            n_cmp++; if (out_valid !== 1'b1 || out_data !== m_od || out_src !== 2'(m_os)) begin
                n_bad++; $display("FAIL bp_hold[%0d]: got v%0b %0h s%0d want v1 %0h s%0d", k, out_valid, out_data, out_src, m_od, m_os);
            end
        end
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_data_random();
            model_eval();
            n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL bp_resume_ready[%0d]: got %b want %b", k, in_ready, exp_rdy); end
            model_clock();
            n_cmp++; if (out_data !== m_od || out_src !== 2'(m_os)) begin n_bad++; $display("FAIL bp_resume[%0d]: got %0h s%0d want %0h s%0d", k, out_data, out_src, m_od, m_os); end
        end
    endtask

    task automatic test_lock_bubble();
        logic [N-1:0] vs [5] = '{4'b1000, 4'b0001, 4'b0001, 4'b1001, 4'b0001};
        logic [N-1:0] ls [5] = '{4'b0111, 4'b0111, 4'b0111, 4'b1111, 4'b1111};
        logic [N-1:0] er [5] = '{4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0001};
        bit           ev [5] = '{1, 0, 0, 1, 1};
        int           es [5] = '{3, 0, 0, 3, 0};
        out_ready = 1'b1;
        in_valid = '0;
        model_eval();
        model_clock();
        for (int k = 0; k < 5; k++) begin
            set_data_random();
            in_valid = vs[k];
            in_last = ls[k];
            model_eval();
            n_cmp++; if (in_ready !== er[k]) begin n_bad++; $display("FAIL lock_ready[%0d]: got %b want %b", k, in_ready, er[k]); end
            model_clock();
            n_cmp++; if (out_valid !== ev[k]) begin n_bad++; $display("FAIL lock_valid[%0d]: got %0b want %0b", k, out_valid, ev[k]); end
            if (ev[k]) begin
                n_cmp++; if (out_src !== 2'(es[k])) begin n_bad++; $display("FAIL lock_src[%0d]: got %0d want %0d", k, out_src, es[k]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        in_valid = 4'b0010;
        in_last = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            in_data[1*W +: W] = 32'hB000_0000 + k;
            model_eval();
            model_clock();
        end
        n_cmp++; if (out_valid !== 1'b1 || out_data !== 32'hB000_0001) begin n_bad++; $display("FAIL mid_beat2: got v%0b %0h want v1 b0000001", out_valid, out_data); end
        #2;
        rst_b = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL mid_async_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 4'b0000) begin n_bad++; $display("FAIL mid_async_ready: got %b want 0000", in_ready); end
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
        in_valid = '1; in_last = '1;
        set_data_random();
        model_eval();
        n_cmp++; if (in_ready !== 4'b0001) begin n_bad++; $display("FAIL mid_first_ready: got %b want 0001", in_ready); end
        model_clock();
        n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd0) begin n_bad++; $display("FAIL mid_first_src: got v%0b s%0d want v1 s0", out_valid, out_src); end
    endtask

    task automatic test_single_src();
        out_ready = 1'b1;
        in_valid = 4'b0100;
        in_last = '1;
        for (int k = 0; k < 6; k++) begin
            set_data_random();
            model_eval();
            n_cmp++; if (in_ready !== 4'b0100) begin n_bad++; $display("FAIL single_ready[%0d]: got %b want 0100", k, in_ready); end
            model_clock();
            n_cmp++; if (out_valid !== 1'b1 || out_src !== 2'd2) begin n_bad++; $display("FAIL single_out[%0d]: got v%0b s%0d want v1 s2", k, out_valid, out_src); end
        end
        in_valid = '1;
        model_eval();
        n_cmp++; if (in_ready !== 4'b1000) begin n_bad++; $display("FAIL single_next_ready: got %b want 1000", in_ready); end
        model_clock();
    endtask

    task automatic test_random();
        int rem [N];
        int seq [N];
        for (int i = 0; i < N; i++) begin
            rem[i] = 1 + int'($urandom_range(3));
            seq[i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                in_valid[i] = ($urandom_range(3) != 0);
                in_data[i*W +: W] = {8'(i), 24'(seq[i])};
                in_last[i] = (rem[i] == 1);
            end
            out_ready = ($urandom_range(9) < 7);
            model_eval();
            n_cmp++; if (in_ready !== exp_rdy) begin n_bad++; $display("FAIL rand_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
            model_clock();
            if (acc_id >= 0) begin
                seq[acc_id]++;
                rem[acc_id]--;
                if (rem[acc_id] == 0) rem[acc_id] = 1 + int'($urandom_range(3));
            end
            n_cmp++; if (out_valid !== m_ov) begin n_bad++; $display("FAIL rand_valid[%0d]: got %0b want %0b", c, out_valid, m_ov); end
            if (m_ov) begin
                n_cmp++; if (out_data !== m_od || out_last !== m_ol || out_src !== 2'(m_os)) begin
                    n_bad++; $display("FAIL rand_beat[%0d]: got %0h l%0b s%0d want %0h l%0b s%0d", c, out_data, out_last, out_src, m_od, m_ol, m_os);
                end
            end
        end
    endtask

    initial begin
        rst_b = 1'b0;
        in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
        model_reset();
        test_reset();
        test_round_robin();
        test_packet();
        test_backpressure();
        test_lock_bubble();
        test_reset_mid();
        test_single_src();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
